// File: rtl/alu_spi_master.sv
// rtl/alu_spi_master.sv - SPI mode-0 initiator for the SPI-attached ALU slave
module alu_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry,
    output logic        overflow,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_TX = 2'd1,
        SHIFT_RX = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [6:0]    bit_q;
    logic [70:0]   tx_q;
    logic [39:0]   rx_q;
    logic          tail_q;
    logic          sclk_q, cs_n_q, mosi_q, busy_q, done_q;
    logic          zero_q, carry_q, overflow_q;
    logic [31:0]   result_q;
    logic [71:0]   tx_frame;
    logic          tick;

    assign tx_frame = {4'b0000, op, a, b};
    assign tick     = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            tail_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= tick ? '0 : cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_q    <= tx_frame[70:0];
                        mosi_q  <= tx_frame[71];
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tail_q  <= 1'b0;
                        state_q <= SHIFT_TX;
                    end
                end
                SHIFT_TX: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 7'd1;
                            if (bit_q == 7'd71) begin
                                mosi_q  <= 1'b0;
                                state_q <= SHIFT_RX;
                            end else begin
                                mosi_q <= tx_q[70];
                                tx_q   <= {tx_q[69:0], 1'b0};
                            end
                        end
                    end
                end
                SHIFT_RX: begin
                    if (tick) begin
                        // tail_q marks the extra half-period cs_n stays low after the last fall
                        if (tail_q) begin
                            cs_n_q     <= 1'b1;
                            done_q     <= 1'b1;
                            result_q   <= rx_q[39:8];
                            overflow_q <= rx_q[2];
                            carry_q    <= rx_q[1];
                            zero_q     <= rx_q[0];
                            tail_q     <= 1'b0;
                            bit_q      <= '0;
                            state_q    <= HOLD;
                        end else if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[38:0], miso};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 7'd111) begin
                                tail_q <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 7'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_alu_spi_master.sv
// tb/tb_alu_spi_master.sv - self-checking bench for alu_spi_master
`timescale 1ns/1ps
module tb_alu_spi_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // D=4 instance
    logic        rst4 = 1'b1, start4 = 1'b0, miso4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0;
    logic [3:0]  op4 = '0;
    logic        busy4, done4, zero4, carry4, ovf4, sclk4, cs_n4, mosi4;
    logic [31:0] result4;

    alu_spi_master #(.CLK_DIV(4)) dut4 (
        .clock(clock), .reset(rst4), .start(start4), .a(a4), .b(b4), .op(op4),
        .busy(busy4), .done(done4), .result(result4), .zero(zero4), .carry(carry4),
        .overflow(ovf4), .sclk(sclk4), .cs_n(cs_n4), .mosi(mosi4), .miso(miso4)
    );

    // D=2 instance for the back-to-back run
    logic        rst2 = 1'b0, start2 = 1'b0, miso2 = 1'b0;
    logic [31:0] a2 = '0, b2 = '0;
    logic [3:0]  op2 = '0;
    logic        busy2, done2, zero2, carry2, ovf2, sclk2, cs_n2, mosi2;
    logic [31:0] result2;

    alu_spi_master #(.CLK_DIV(2)) dut2 (
        .clock(clock), .reset(rst2), .start(start2), .a(a2), .b(b2), .op(op2),
        .busy(busy2), .done(done2), .result(result2), .zero(zero2), .carry(carry2),
        .overflow(ovf2), .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(miso2)
    );

    // Slave model and monitors for the D=4 instance, sampled on the falling clock
    logic [39:0] resp4 = '0;
    logic [71:0] cap4 = '0;
    int rises4 = 0, falls4 = 0, viol4 = 0, dones4 = 0;
    logic sclk4_p = 1'b0, cs4_p = 1'b1;

    always @(negedge clock) begin
        if (cs4_p && !cs_n4) begin
            rises4 = 0;
            falls4 = 0;
            cap4   = '0;
        end
        if (!cs_n4 && sclk4 && !sclk4_p) begin
            if (rises4 < 72) cap4 = {cap4[70:0], mosi4};
            rises4++;
        end
        if (!cs_n4 && !sclk4 && sclk4_p) begin
            falls4++;
            miso4 = (falls4 >= 72 && falls4 < 112) ? resp4[39 - (falls4 - 72)] : 1'b0;
        end
        if (rst4 && cs_n4 && sclk4) viol4++;
        if (done4) dones4++;
        sclk4_p = sclk4;
        cs4_p   = cs_n4;
    end

    int done_t2[$];
    int viol2 = 0, hi_run2 = 0, min_gap2 = 100000;
    logic seen_frame2 = 1'b0;

    always @(negedge clock) begin
        if (rst2) begin
            if (done2) done_t2.push_back(cyc);
            if (cs_n2 && sclk2) viol2++;
            if (cs_n2) begin
                hi_run2++;
            end else begin
                if (seen_frame2 && hi_run2 > 0 && hi_run2 < min_gap2) min_gap2 = hi_run2;
                seen_frame2 = 1'b1;
                hi_run2 = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cs_n"}, cs_n4, 1'b1);
        chk({tag, "_sclk"}, sclk4, 1'b0);
        chk({tag, "_mosi"}, mosi4, 1'b0);
        chk({tag, "_busy"}, busy4, 1'b0);
        chk({tag, "_done"}, done4, 1'b0);
        chk({tag, "_result"}, result4, 32'd0);
        chk({tag, "_flags"}, {zero4, carry4, ovf4}, 3'b000);
    endtask

    int k4;

    task automatic launch4(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [39:0] resp);
        @(negedge clock);
        op4 = op; a4 = a; b4 = b; resp4 = resp; start4 = 1'b1;
        @(posedge clock);
        #1;
        k4 = cyc;
        start4 = 1'b0;
        chk("accept_busy", busy4, 1'b1);
        chk("accept_cs_n", cs_n4, 1'b0);
    endtask

    task automatic wait_done4(output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (done4) begin
                lat = cyc - k4;
                break;
            end
        end
    endtask

    task automatic wait_idle4();
        int g;
        g = 0;
        while (busy4 && g < 100) begin
            @(negedge clock);
            g++;
        end
        chk("idle_wait", busy4, 1'b0);
    endtask

    task automatic wait_rises4(input int n);
        int g;
        g = 0;
        while (rises4 < n && g < 5000) begin
            @(negedge clock);
            g++;
        end
        chk("rise_wait", rises4 >= n, 1'b1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [39:0] resp;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int d0;

        vecs[0] = '{4'd0, 32'd5,         32'd7,         {32'h0000000C, 8'h00}, 32'h0000000C, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd2, 32'hF0F0F0F0,  32'h0F0F0F0F,  {32'h00000000, 8'hFF}, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{4'd6, 32'h00000001,  32'h00000004,  {32'hDEADBEEF, 8'hF8}, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{4'd8, 32'h80000000,  32'h00000001,  {32'hC0000000, 8'h02}, 32'hC0000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'd0, 32'h7FFFFFFF,  32'h00000001,  {32'h80000000, 8'h04}, 32'h80000000, 1'b0, 1'b0, 1'b1};

        #2 rst4 = 1'b0;
        #1 chk_reset_outs("por");
        repeat (2) @(negedge clock);
        rst4 = 1'b1;

        for (int i = 0; i < 5; i++) begin
            launch4(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].resp);
            wait_done4(lat);
            chk($sformatf("v%0d_latency", i), lat, 900);
            chk($sformatf("v%0d_result", i), result4, vecs[i].res);
            chk($sformatf("v%0d_zero", i), zero4, vecs[i].z);
            chk($sformatf("v%0d_carry", i), carry4, vecs[i].c);
            chk($sformatf("v%0d_overflow", i), ovf4, vecs[i].v);
            chk($sformatf("v%0d_mosi", i), cap4, {4'b0000, vecs[i].op, vecs[i].a, vecs[i].b});
            chk($sformatf("v%0d_rises", i), rises4, 112);
            @(negedge clock);
            chk($sformatf("v%0d_done_pulse", i), done4, 1'b0);
            wait_idle4();
        end
        chk("add_mosi_literal", 72'h00_00000005_00000007, {4'b0000, vecs[0].op, vecs[0].a, vecs[0].b});

        // reset while idle
        repeat (3) @(negedge clock);
        #2 rst4 = 1'b0;
        #1 chk_reset_outs("idle_rst");
        @(negedge clock);
        rst4 = 1'b1;

        // start and input changes while busy
        launch4(4'd2, 32'h12345678, 32'h9ABCDEF0, {32'h10305070, 8'h00});
        d0 = dones4;
        wait_rises4(30);
        @(negedge clock);
        op4 = 4'd1;
        start4 = 1'b1;
        @(negedge clock);
        start4 = 1'b0;
        wait_rises4(40);
        a4 = 32'hFFFFFFFF;
        wait_done4(lat);
        chk("busy_latency", lat, 900);
        chk("busy_mosi", cap4, {4'b0000, 4'd2, 32'h12345678, 32'h9ABCDEF0});
        chk("busy_result", result4, 32'h10305070);
        wait_idle4();
        repeat (20) @(negedge clock);
        chk("busy_single_done", dones4 - d0, 1);

        // reset mid-frame
        launch4(4'd4, 32'hAAAAAAAA, 32'h55555555, {32'hFFFFFFFF, 8'h00});
        d0 = dones4;
        wait_rises4(50);
        #3 rst4 = 1'b0;
        #1 chk("abort_cs_n", cs_n4, 1'b1);
        chk("abort_sclk", sclk4, 1'b0);
        chk("abort_busy", busy4, 1'b0);
        chk("abort_result", result4, 32'd0);
        repeat (3) @(negedge clock);
        rst4 = 1'b1;
        repeat (300) @(negedge clock);
        chk("abort_no_done", dones4 - d0, 0);

        launch4(4'd1, 32'd3, 32'd3, {32'h00000000, 8'h01});
        wait_done4(lat);
        chk("sub_latency", lat, 900);
        chk("sub_result", result4, 32'd0);
        chk("sub_flags", {zero4, carry4, ovf4}, 3'b100);
        chk("sub_mosi", cap4, 72'h01_00000003_00000003);
        wait_idle4();

        // back-to-back at D=2 with start held
        @(negedge clock);
        op2 = 4'd0; a2 = 32'd1; b2 = 32'd2; start2 = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < 2000 && done_t2.size() < 3; i++) @(negedge clock);
        start2 = 1'b0;
        chk("b2b_done_count", done_t2.size() >= 3, 1'b1);
        if (done_t2.size() >= 3) begin
            chk("b2b_period0", done_t2[1] - done_t2[0], 453);
            chk("b2b_period1", done_t2[2] - done_t2[1], 453);
        end
        chk("b2b_min_gap", min_gap2 >= 3, 1'b1);
        chk("b2b_sclk_low", viol2, 0);
        chk("d4_sclk_low", viol4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
